// File: rtl/sng_pair_pkg.sv
// rtl/sng_pair_pkg.sv - shared FSM state encoding and default sizing for sng_pair
package sng_pair_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_FRAME_LOG2 = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sng_state_e;

endpackage

// File: rtl/sng_pair_cmp.sv
// rtl/sng_pair_cmp.sv - sng_cmp: latched operand, comparator and registered stochastic bit
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture x_in into the operand register
//   en        : emit the comparison result on the next edge (otherwise the bit is forced 0)
//   x_in      : operand to latch
//   rnd       : random word compared against the latched operand
//   hit       : rnd < latched operand, for the parent's ones counter (feeds flops only)
//   bit_out   : registered stochastic bit
module sng_cmp
    import sng_pair_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] rnd,
    output logic             hit,
    output logic             bit_out
);

    logic [WIDTH-1:0] x_q, x_d;
    logic             bit_q, bit_d;

    always_comb begin
        x_d   = x_q;
        if (load) begin
            x_d = x_in;
        end
        hit   = (rnd < x_q);
        bit_d = en & hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            bit_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            bit_q <= bit_d;
        end
    end

    assign bit_out = bit_q;

endmodule

// File: rtl/sng_pair.sv
// rtl/sng_pair.sv - paired stochastic number generator producing framed bitstreams
//
// Ports:
//   TRIG, RESET          : clock, asynchronous active-high reset
//   RND1, RND2           : random words from the upstream LFSR
//   X1, X2               : operands (probability X/2^WIDTH), latched on load
//   IN_VALID / IN_READY  : operand-load handshake, ready only in IDLE
//   ABORT                : cancel the current frame, return to IDLE
//   S1, S2, S_VALID      : registered stochastic bits and their qualifier
//   FRAME_LAST           : qualifies the final bit of a frame
//   DONE                 : one-cycle pulse after a completed frame
//   CNT1                 : ones count on S1 over the last completed frame
module sng_pair
    import sng_pair_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int FRAME_LOG2 = DEFAULT_FRAME_LOG2
) (
    input  logic              TRIG,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  RND1,
    input  logic [WIDTH-1:0]  RND2,
    input  logic [WIDTH-1:0]  X1,
    input  logic [WIDTH-1:0]  X2,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              ABORT,
    output logic              S1,
    output logic              S2,
    output logic              S_VALID,
    output logic              FRAME_LAST,
    output logic              DONE,
    output logic [FRAME_LOG2:0] CNT1
);

    localparam int CW = FRAME_LOG2 + 1;

    sng_state_e            state_q, state_d;
    logic [FRAME_LOG2-1:0] frame_q, frame_d;
    logic [CW-1:0]         ones_q, ones_d;
    logic [CW-1:0]         cnt1_q, cnt1_d;
    logic                  s_valid_q, s_valid_d;
    logic                  frame_last_q, frame_last_d;
    logic                  done_q, done_d;
    logic                  load, run_en;
    logic                  hit1, hit2;

    sng_cmp #(.WIDTH(WIDTH)) u_cmp1 (
        .clk     (TRIG),
        .rst     (RESET),
        .load    (load),
        .en      (run_en),
        .x_in    (X1),
        .rnd     (RND1),
        .hit     (hit1),
        .bit_out (S1)
    );

    sng_cmp #(.WIDTH(WIDTH)) u_cmp2 (
        .clk     (TRIG),
        .rst     (RESET),
        .load    (load),
        .en      (run_en),
        .x_in    (X2),
        .rnd     (RND2),
        .hit     (hit2),
        .bit_out (S2)
    );

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        ones_d       = ones_q;
        cnt1_d       = cnt1_q;
        s_valid_d    = 1'b0;
        frame_last_d = 1'b0;
        done_d       = 1'b0;
        load         = 1'b0;
        run_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // ABORT has priority over a load request
                if (IN_VALID && !ABORT) begin
                    load    = 1'b1;
                    frame_d = '0;
                    ones_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else begin
                    run_en    = 1'b1;
                    s_valid_d = 1'b1;
                    frame_d   = frame_q + 1'b1;
                    ones_d    = ones_q + CW'(hit1);
                    if (frame_q == {FRAME_LOG2{1'b1}}) begin
                        frame_last_d = 1'b1;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // The last bit is on the outputs during this state; the
                // completion pulse and count publish follow it.
                state_d = ST_IDLE;
                if (!ABORT) begin
                    done_d = 1'b1;
                    cnt1_d = ones_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge TRIG or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            ones_q       <= '0;
            cnt1_q       <= '0;
            s_valid_q    <= 1'b0;
            frame_last_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            ones_q       <= ones_d;
            cnt1_q       <= cnt1_d;
            s_valid_q    <= s_valid_d;
            frame_last_q <= frame_last_d;
            done_q       <= done_d;
        end
    end

    assign IN_READY   = (state_q == ST_IDLE);
    assign S_VALID    = s_valid_q;
    assign FRAME_LAST = frame_last_q;
    assign DONE       = done_q;
    assign CNT1       = cnt1_q;

endmodule

// File: tb/tb_sng_pair.sv
// tb/tb_sng_pair.sv - self-checking bench for sng_pair (8-bit and 256-bit frame instances)
module tb_sng_pair;

    logic       TRIG = 1'b0;
    logic       RESET;
    logic [7:0] RND1, RND2, X1, X2;
    logic       IN_VALID, ABORT;

    logic       s1_a, s2_a, sv_a, fl_a, done_a, rdy_a;
    logic [3:0] cnt_a;
    logic       s1_b, s2_b, sv_b, fl_b, done_b, rdy_b;
    logic [8:0] cnt_b;

    logic [5:0] obs_a, obs_b;
    assign obs_a = {s1_a, s2_a, sv_a, fl_a, done_a, rdy_a};
    assign obs_b = {s1_b, s2_b, sv_b, fl_b, done_b, rdy_b};

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [3:0] exp_cnt_a;

    always #5 TRIG = ~TRIG;

    sng_pair #(.WIDTH(8), .FRAME_LOG2(3)) dut_a (
        .TRIG(TRIG), .RESET(RESET), .RND1(RND1), .RND2(RND2), .X1(X1), .X2(X2),
        .IN_VALID(IN_VALID), .IN_READY(rdy_a), .ABORT(ABORT),
        .S1(s1_a), .S2(s2_a), .S_VALID(sv_a), .FRAME_LAST(fl_a), .DONE(done_a), .CNT1(cnt_a)
    );

    sng_pair #(.WIDTH(8), .FRAME_LOG2(8)) dut_b (
        .TRIG(TRIG), .RESET(RESET), .RND1(RND1), .RND2(RND2), .X1(X1), .X2(X2),
        .IN_VALID(IN_VALID), .IN_READY(rdy_b), .ABORT(ABORT),
        .S1(s1_b), .S2(s2_b), .S_VALID(sv_b), .FRAME_LAST(fl_b), .DONE(done_b), .CNT1(cnt_b)
    );

    task automatic step;
        @(posedge TRIG);
        #1;
    endtask

    // One 8-bit frame on dut_a: load, 8 bits checked against rnd<x, then the DONE cycle.
    task automatic run_frame3(input logic [7:0] x1, input logic [7:0] x2,
                              input bit rand_rnd, input logic [7:0] frnd, input bit hold);
        logic [7:0] r1, r2;
        logic [5:0] exp;
        int ones;
        X1 = x1; X2 = x2; IN_VALID = 1'b1; ABORT = 1'b0;
        step;
        n_cmp++;
        if (obs_a !== 6'b000000) begin
            n_fail++; $display("FAIL load_gap: got %b want %b", obs_a, 6'b000000);
        end
        if (!hold) IN_VALID = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            r1 = rand_rnd ? 8'($urandom) : frnd;
            r2 = rand_rnd ? 8'($urandom) : frnd;
            RND1 = r1; RND2 = r2;
            X1 = 8'($urandom); X2 = 8'($urandom);
            step;
            exp = {r1 < x1, r2 < x2, 1'b1, (i == 7), 2'b00};
            if (r1 < x1) ones++;
            n_cmp++;
            if (obs_a !== exp) begin
                n_fail++; $display("FAIL bit%0d x1=%h x2=%h: got %b want %b", i, x1, x2, obs_a, exp);
            end
        end
        step;
        exp_cnt_a = 4'(ones);
        n_cmp++;
        if (obs_a !== 6'b000011) begin
            n_fail++; $display("FAIL done_pulse: got %b want %b", obs_a, 6'b000011);
        end
        n_cmp++;
        if (cnt_a !== exp_cnt_a) begin
            n_fail++; $display("FAIL cnt1: got %0d want %0d", cnt_a, exp_cnt_a);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if (obs_a !== 6'b000001 || cnt_a !== 4'd0) begin
            n_fail++; $display("FAIL reset_a: got %b/%0d want 000001/0", obs_a, cnt_a);
        end
        n_cmp++;
        if (obs_b !== 6'b000001 || cnt_b !== 9'd0) begin
            n_fail++; $display("FAIL reset_b: got %b/%0d want 000001/0", obs_b, cnt_b);
        end
        RESET = 1'b0;
        step;
        n_cmp++;
        if (obs_a !== 6'b000001) begin
            n_fail++; $display("FAIL post_reset_idle: got %b want 000001", obs_a);
        end
    endtask

    task automatic test_fixed;
        run_frame3(8'h80, 8'h20, 1'b0, 8'h40, 1'b0);
        n_cmp++;
        if (cnt_a !== 4'd8) begin
            n_fail++; $display("FAIL fixed_cnt1: got %0d want 8", cnt_a);
        end
    endtask

    task automatic test_random;
        run_frame3(8'h00, 8'hFF, 1'b1, 8'h00, 1'b0);
        run_frame3(8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0);
        run_frame3(8'hFF, 8'h00, 1'b0, 8'hFE, 1'b0);
        for (int k = 0; k < 5; k++) begin
            run_frame3(8'($urandom), 8'($urandom), 1'b1, 8'h00, 1'b0);
        end
    endtask

    task automatic test_lfsr(input logic [7:0] x);
        logic [15:0] lfsr;
        logic [5:0]  exp;
        int ones;
        lfsr = 16'hACE1;
        ones = 0;
        RESET = 1'b1; #1; RESET = 1'b0;
        X1 = x; X2 = 8'($urandom); IN_VALID = 1'b1; ABORT = 1'b0;
        step;
        IN_VALID = 1'b0;
        for (int i = 0; i < 256; i++) begin
            RND1 = lfsr[7:0]; RND2 = lfsr[15:8];
            if (lfsr[7:0] < x) ones++;
            exp = {lfsr[7:0] < x, 1'bx, 1'b1, (i == 255), 2'b00};
            step;
            lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            n_cmp++;
            if ({obs_b[5], obs_b[3:0]} !== {exp[5], exp[3:0]}) begin
                n_fail++; $display("FAIL lfsr_bit%0d x=%h: got %b want %b", i, x, obs_b, exp);
            end
        end
        step;
        n_cmp++;
        if (done_b !== 1'b1 || sv_b !== 1'b0) begin
            n_fail++; $display("FAIL lfsr_done x=%h: got done=%b sv=%b want 1/0", x, done_b, sv_b);
        end
        n_cmp++;
        if (cnt_b !== 9'(ones)) begin
            n_fail++; $display("FAIL lfsr_cnt1 x=%h: got %0d want %0d", x, cnt_b, ones);
        end
    endtask

    task automatic test_abort;
        logic [7:0] r1, x1;
        run_frame3(8'($urandom), 8'($urandom), 1'b1, 8'h00, 1'b0);
        x1 = 8'($urandom);
        X1 = x1; IN_VALID = 1'b1;
        step;
        IN_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r1 = 8'($urandom); RND1 = r1;
            step;
            n_cmp++;
            if ({s1_a, sv_a} !== {r1 < x1, 1'b1}) begin
                n_fail++; $display("FAIL abort_pre%0d: got %b%b want %b1", i, s1_a, sv_a, r1 < x1);
            end
        end
        ABORT = 1'b1;
        step;
        n_cmp++;
        if (obs_a !== 6'b000001 || cnt_a !== exp_cnt_a) begin
            n_fail++; $display("FAIL abort_next: got %b/%0d want 000001/%0d", obs_a, cnt_a, exp_cnt_a);
        end
        ABORT = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step;
            n_cmp++;
            if (obs_a !== 6'b000001 || cnt_a !== exp_cnt_a) begin
                n_fail++; $display("FAIL abort_idle%0d: got %b/%0d want 000001/%0d", i, obs_a, cnt_a, exp_cnt_a);
            end
        end
        // abort while the final bit is being shown: no DONE pulse
        X1 = 8'hFF; IN_VALID = 1'b1;
        step;
        IN_VALID = 1'b0;
        RND1 = 8'h00;
        for (int i = 0; i < 8; i++) step;
        n_cmp++;
        if (fl_a !== 1'b1) begin
            n_fail++; $display("FAIL abort_last_bit: got fl=%b want 1", fl_a);
        end
        ABORT = 1'b1;
        step;
        ABORT = 1'b0;
        n_cmp++;
        if (obs_a !== 6'b000001 || cnt_a !== exp_cnt_a) begin
            n_fail++; $display("FAIL abort_in_done: got %b/%0d want 000001/%0d", obs_a, cnt_a, exp_cnt_a);
        end
    endtask

    task automatic test_reset_mid;
        X1 = 8'hFF; X2 = 8'hFF; RND1 = 8'h00; RND2 = 8'h00; IN_VALID = 1'b1;
        step;
        IN_VALID = 1'b0;
        repeat (3) step;
        #2 RESET = 1'b1;
        #1;
        n_cmp++;
        if (obs_a !== 6'b000001 || cnt_a !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid: got %b/%0d want 000001/0", obs_a, cnt_a);
        end
        exp_cnt_a = 4'd0;
        #2 RESET = 1'b0;
        run_frame3(8'($urandom), 8'($urandom), 1'b1, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 4; f++) begin
            run_frame3(8'($urandom), 8'($urandom), 1'b1, 8'h00, 1'b1);
        end
        IN_VALID = 1'b0;
        step;
    endtask

    task automatic test_abort_valid_idle;
        IN_VALID = 1'b1; ABORT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            n_cmp++;
            if (obs_a !== 6'b000001) begin
                n_fail++; $display("FAIL abort_valid_idle%0d: got %b want 000001", i, obs_a);
            end
        end
        IN_VALID = 1'b0; ABORT = 1'b0;
        step;
        n_cmp++;
        if (obs_a !== 6'b000001) begin
            n_fail++; $display("FAIL abort_valid_after: got %b want 000001", obs_a);
        end
    endtask

    initial begin
        RESET = 1'b1; RND1 = '0; RND2 = '0; X1 = '0; X2 = '0;
        IN_VALID = 1'b0; ABORT = 1'b0; exp_cnt_a = '0;
        repeat (2) @(posedge TRIG);
        #1;
        test_reset;
        test_fixed;
        test_random;
        test_lfsr(8'h00);
        test_lfsr(8'hFF);
        test_abort;
        test_reset_mid;
        test_back_to_back;
        test_abort_valid_idle;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
